// File: rtl/npc_pkg.sv
// npc_pkg: next-PC select codes shared with the controller, plus delay-slot FSM states.
package npc_pkg;
  localparam logic [2:0] NPC_SEQ  = 3'b000;
  localparam logic [2:0] NPC_BEQ  = 3'b001;
  localparam logic [2:0] NPC_J    = 3'b010;
  localparam logic [2:0] NPC_JAL  = 3'b011;
  localparam logic [2:0] NPC_JR   = 3'b100;
  localparam logic [2:0] NPC_JALR = 3'b101;
  typedef enum logic {ST_NORMAL, ST_SLOT} ds_state_t;
endpackage

// File: rtl/ras_stack.sv
// ras_stack: circular return-address stack; a push when full overwrites the oldest entry.
module ras_stack #(
  parameter int ADDR_W    = 32,
  parameter int RAS_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] wdata,
  output logic [ADDR_W-1:0] top,
  output logic              empty,
  output logic              full
);
  localparam int PW = $clog2(RAS_DEPTH);
  logic [ADDR_W-1:0] mem [RAS_DEPTH];
  logic [PW-1:0] ptr, top_idx;
  logic [PW:0] count;
  assign empty   = count == '0;
  assign full    = count == (PW+1)'(RAS_DEPTH);
  assign top_idx = ptr - 1'b1;
  assign top     = empty ? '0 : mem[top_idx];
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr   <= '0;
      count <= '0;
    end else if (push) begin
      ptr   <= ptr + 1'b1;
      count <= full ? count : count + 1'b1;
    end else if (pop && !empty) begin
      ptr   <= ptr - 1'b1;
      count <= count - 1'b1;
    end
  end
  // ptr always addresses the oldest slot once full, so wrap-around overwrites it
  always_ff @(posedge clk) begin
    if (push) mem[ptr] <= wdata;
  end
endmodule

// File: rtl/npc_ras.sv
// npc_ras: registered fetch PC with next-PC mux, optional delay-slot FSM and return-address stack.
module npc_ras
  import npc_pkg::*;
#(
  parameter int                ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] RESET_PC   = 32'h0000_3000,
  parameter int                RAS_DEPTH  = 4,
  parameter int                DELAY_SLOT = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic [2:0]        npc_slc,
  input  logic              br_taken,
  input  logic [25:0]       imm26,
  input  logic [ADDR_W-1:0] offset,
  input  logic [ADDR_W-1:0] rs_val,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_4,
  output logic [ADDR_W-1:0] link_addr,
  output logic [ADDR_W-1:0] ras_top,
  output logic              ras_hit,
  output logic              ras_empty,
  output logic              ras_full
);
  ds_state_t state, state_next;
  logic [ADDR_W-1:0] pend, pc_next, tgt, br_tgt, j_tgt;
  logic [2:0] sel;
  logic redirect, in_slot, push, pop;
  assign sel       = npc_slc > NPC_JALR ? NPC_SEQ : npc_slc;
  assign pc_4      = pc + ADDR_W'(4);
  assign link_addr = pc + ADDR_W'(DELAY_SLOT != 0 ? 8 : 4);
  assign br_tgt    = pc_4 + (offset << 2);
  assign j_tgt     = (pc_4 & ~ADDR_W'(28'hFFF_FFFF)) | ADDR_W'({imm26, 2'b00});
  assign redirect  = sel != NPC_SEQ && !(sel == NPC_BEQ && !br_taken);
  assign in_slot   = DELAY_SLOT != 0 && state == ST_SLOT;
  always_comb begin
    tgt = (sel == NPC_BEQ && br_taken) ? br_tgt :
          (sel == NPC_J || sel == NPC_JAL) ? j_tgt :
          (sel == NPC_JR || sel == NPC_JALR) ? rs_val : pc_4;
    state_next = (DELAY_SLOT != 0 && !in_slot && redirect) ? ST_SLOT : ST_NORMAL;
    pc_next = in_slot ? pend : (state_next == ST_SLOT) ? pc_4 : tgt;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc    <= RESET_PC;
      state <= ST_NORMAL;
      pend  <= '0;
    end else if (!stall) begin
      pc    <= pc_next;
      state <= state_next;
      if (state_next == ST_SLOT) pend <= tgt;
    end
  end
  // the delay slot is not a real control transfer, so it never touches the RAS
  assign push    = !stall && !in_slot && (sel == NPC_JAL || sel == NPC_JALR);
  assign pop     = !stall && !in_slot && sel == NPC_JR;
  assign ras_hit = npc_slc == NPC_JR && !ras_empty && rs_val == ras_top;
  ras_stack #(.ADDR_W(ADDR_W), .RAS_DEPTH(RAS_DEPTH)) u_ras (
    .clk(clk),
    .reset(reset),
    .push(push),
    .pop(pop),
    .wdata(link_addr),
    .top(ras_top),
    .empty(ras_empty),
    .full(ras_full)
  );
endmodule

// File: tb/tb_npc_ras.sv
// tb_npc_ras: drives a plain and a delay-slot npc_ras with shared inputs against a queue-based reference.
module tb_npc_ras;
  logic clk = 0, reset = 1, stall = 0, br_taken = 0;
  logic [2:0] npc_slc = 0;
  logic [25:0] imm26 = 0;
  logic [31:0] offset = 0, rs_val = 0;
  logic [31:0] pc_o [2], pc4_o [2], link_o [2], top_o [2];
  logic hit_o [2], empty_o [2], full_o [2];
  int checks = 0, errors = 0, hits = 0;
  logic [31:0] m_pc [2], m_pend [2];
  bit m_slot [2];
  logic [31:0] q0 [$], q1 [$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    npc_ras #(.DELAY_SLOT(g)) dut (
      .clk(clk), .reset(reset), .stall(stall), .npc_slc(npc_slc), .br_taken(br_taken),
      .imm26(imm26), .offset(offset), .rs_val(rs_val), .pc(pc_o[g]), .pc_4(pc4_o[g]),
      .link_addr(link_o[g]), .ras_top(top_o[g]), .ras_hit(hit_o[g]),
      .ras_empty(empty_o[g]), .ras_full(full_o[g])
    );
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int qsize(input int d);
    return d == 0 ? q0.size() : q1.size();
  endfunction

  function automatic logic [31:0] qtop(input int d);
    if (qsize(d) == 0) return 32'h0;
    return d == 0 ? q0[$] : q1[$];
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_pc[d] = 32'h3000;
      m_pend[d] = 0;
      m_slot[d] = 0;
    end
    q0.delete();
    q1.delete();
  endtask

  task automatic check_regs(input string tag);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("%s pc[%0d]", tag, d), pc_o[d], m_pc[d]);
      chk($sformatf("%s empty[%0d]", tag, d), 32'(empty_o[d]), 32'(qsize(d) == 0));
      chk($sformatf("%s full[%0d]", tag, d), 32'(full_o[d]), 32'(qsize(d) == 4));
    end
  endtask

  task automatic do_reset();
    reset = 1;
    model_reset();
    @(posedge clk);
    #1;
    check_regs("reset");
    chk("reset top", top_o[0], 32'h0);
    reset = 0;
  endtask

  task automatic step(input logic [2:0] s, input logic bt, input logic [25:0] im,
                      input logic [31:0] of, input logic [31:0] rv, input logic st);
    int sel;
    logic [31:0] p, tgt, link;
    bit redir;
    npc_slc = s; br_taken = bt; imm26 = im; offset = of; rs_val = rv; stall = st;
    #1;
    for (int d = 0; d < 2; d++) begin
      p = m_pc[d];
      link = p + (d == 1 ? 8 : 4);
      chk("pc_4", pc4_o[d], p + 4);
      chk("link_addr", link_o[d], link);
      chk("ras_top", top_o[d], qtop(d));
      chk("ras_hit", 32'(hit_o[d]), 32'(s == 3'd4 && qsize(d) > 0 && rv == qtop(d)));
      if (d == 0 && hit_o[0]) hits++;
      sel = s > 3'd5 ? 0 : int'(s);
      case (sel)
        1: tgt = bt ? p + 4 + (of << 2) : p + 4;
        2, 3: tgt = {p[31:28] + ((p + 4) >> 28 != p >> 28 ? 4'd1 : 4'd0), im, 2'b00};
        4, 5: tgt = rv;
        default: tgt = p + 4;
      endcase
      redir = sel != 0 && !(sel == 1 && !bt);
      if (st) continue;
      if (d == 1 && m_slot[d]) begin
        m_pc[d] = m_pend[d];
        m_slot[d] = 0;
        continue;
      end
      if (sel == 3 || sel == 5) begin
        if (d == 0) begin q0.push_back(link); if (q0.size() > 4) void'(q0.pop_front()); end
        else begin q1.push_back(link); if (q1.size() > 4) void'(q1.pop_front()); end
      end
      if (sel == 4) begin
        if (d == 0 && q0.size() > 0) void'(q0.pop_back());
        if (d == 1 && q1.size() > 0) void'(q1.pop_back());
      end
      if (d == 1 && redir) begin
        m_pend[d] = tgt;
        m_pc[d] = p + 4;
        m_slot[d] = 1;
      end else m_pc[d] = tgt;
    end
    @(posedge clk);
    #1;
    check_regs("step");
  endtask

  initial begin
    logic [31:0] rv;
    model_reset();
    #1;
    do_reset();
    repeat (3) step(0, 0, 0, 0, 0, 0);
    chk("seq3", pc_o[0], 32'h300C);
    step(0, 0, 0, 0, 0, 0);
    step(1, 1, 0, 32'hFFFF_FFFF, 0, 0);
    chk("beq taken", pc_o[0], 32'h3010);
    step(1, 0, 0, 32'hFFFF_FFFF, 0, 0);
    chk("beq not taken", pc_o[0], 32'h3014);

    do_reset();
    step(3, 0, 26'h0000C40, 0, 0, 0);
    chk("jal pc", pc_o[0], 32'h3100);
    chk("jal top", top_o[0], 32'h3004);
    npc_slc = 4; rs_val = 32'h3004;
    #1;
    chk("jr hit", 32'(hit_o[0]), 1);
    step(4, 0, 0, 0, 32'h3004, 0);
    chk("jr pc", pc_o[0], 32'h3004);
    chk("jr empty", 32'(empty_o[0]), 1);

    do_reset();
    for (int i = 0; i < 5; i++) step(3, 0, 26'h1000 + 26'(i * 'h40), 0, 0, 0);
    chk("ovf full", 32'(full_o[0]), 1);
    hits = 0;
    for (int i = 4; i >= 0; i--) step(4, 0, 0, 0, i == 0 ? 32'h3004 : 32'h4004 + 32'((i - 1) * 'h100), 0);
    chk("ovf hits", hits, 4);
    chk("ovf empty", 32'(empty_o[0]), 1);

    do_reset();
    step(2, 0, 26'h0000D00, 0, 0, 0);
    chk("ds slot pc", pc_o[1], 32'h3004);
    step(0, 0, 0, 0, 0, 0);
    chk("ds target", pc_o[1], 32'h3400);

    do_reset();
    step(2, 0, 26'h0000D00, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    chk("ds stall", pc_o[1], 32'h3004);
    step(0, 0, 0, 0, 0, 0);
    chk("ds after stall", pc_o[1], 32'h3400);

    do_reset();
    step(2, 0, 26'h0000D00, 0, 0, 0);
    reset = 1;
    #1;
    chk("async reset pc", pc_o[1], 32'h3000);
    model_reset();
    @(posedge clk);
    #1;
    reset = 0;
    step(0, 0, 0, 0, 0, 0);
    chk("pend discarded", pc_o[1], 32'h3004);

    for (int i = 0; i < 400; i++) begin
      rv = $urandom_range(0, 1) ? qtop(0) : {$urandom_range(0, 32'hFFFF), 2'b00};
      step(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 26'($urandom),
           32'(signed'(int'($urandom_range(0, 64)) - 32)), rv, $urandom_range(0, 4) == 0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
